// File: rtl/hs32_mem_pkg.sv
// Shared types and constants for the hs32 memory arbiter.
package hs32_mem_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

    localparam logic RwRead  = 1'b0;
    localparam logic RwWrite = 1'b1;

    localparam int unsigned DefAw = 32;
    localparam int unsigned DefDw = 32;

endpackage

// File: rtl/hs32_arb_pick.sv
// Combinational picker: first pending channel at or after start_i, wrapping to the lowest index.
module hs32_arb_pick #(
    parameter int unsigned NCH = 2,
    parameter int unsigned IW  = 1
) (
    input  logic [NCH-1:0] pend_i,
    input  logic [IW-1:0]  start_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o,
    output logic           valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!valid_o && pend_i[i] && (IW'(i) >= start_i)) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
        // Nothing at or above the start point: wrap around to the lowest pending index.
        for (int i = 0; i < NCH; i++) begin
            if (!valid_o && pend_i[i]) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/hs32_mem_arb.sv
// N-channel arbiter multiplexing latched channel requests onto the hs32 external bus.
// Define HS32_MEMARB_RR_EN for round-robin arbitration; fixed priority (channel 0 first) otherwise.
module hs32_mem_arb
    import hs32_mem_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned AW      = DefAw,
    parameter int unsigned DW      = DefDw,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    output logic [AW-1:0]     addr,
    output logic              rw,
    input  logic [DW-1:0]     din,
    output logic [DW-1:0]     dout,
    output logic              stb,
    input  logic              ack,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_dtw,
    input  logic [NCH-1:0]    ch_rw,
    input  logic [NCH-1:0]    ch_stb,
    output logic [NCH*DW-1:0] ch_dtr,
    output logic [NCH-1:0]    ch_ack,
    output logic [NCH-1:0]    ch_stl,
    output logic [NCH-1:0]    ch_err
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [TMO_W-1:0] TmoLast = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

    arb_state_e state_q, state_d;
    logic [NCH-1:0]         pend_q, pend_d;
    logic [IW-1:0]          own_q, own_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          dout_q, dout_d;
    logic                   rw_q, rw_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   kill_q, kill_d;
    logic [NCH-1:0][DW-1:0] dtr_q, dtr_d;
    logic [NCH-1:0]         ack_q, ack_d;
    logic [NCH-1:0]         err_q, err_d;

    logic [NCH-1:0][AW-1:0] slot_addr_q;
    logic [NCH-1:0][DW-1:0] slot_dtw_q;
    logic [NCH-1:0]         slot_rw_q;

    logic [NCH-1:0] cap, own_vec, pick_gnt;
    logic [IW-1:0]  pick_idx, pick_start;
    logic           pick_valid, done, timed;

`ifdef HS32_MEMARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    assign pick_start = (ptr_q == IW'(NCH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_d      = (state_q == StIdle && pick_valid && !flush) ? pick_idx : ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= IW'(NCH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pick_start = '0;
`endif

    hs32_arb_pick #(
        .NCH(NCH),
        .IW (IW)
    ) u_pick (
        .pend_i (pend_q),
        .start_i(pick_start),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .valid_o(pick_valid)
    );

    always_comb begin
        own_vec = '0;
        for (int i = 0; i < NCH; i++) begin
            own_vec[i] = (state_q != StIdle) && (own_q == IW'(i));
        end
    end

    assign ch_stl = pend_q | own_vec;
    assign cap    = ch_stb & ~ch_stl & {NCH{~flush}};
    assign stb    = (state_q == StIssue);
    assign addr   = addr_q;
    assign dout   = dout_q;
    assign rw     = rw_q;
    assign ch_dtr = dtr_q;
    assign ch_ack = ack_q;
    assign ch_err = err_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        own_d   = own_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rw_d    = rw_q;
        tmo_d   = tmo_q;
        kill_d  = kill_q;
        dtr_d   = dtr_q;
        ack_d   = '0;
        err_d   = '0;
        done    = 1'b0;
        timed   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A flush in the grant cycle drops the would-be winner along with the rest.
                if (pick_valid && !flush) begin
                    own_d   = pick_idx;
                    pend_d  = pend_q & ~pick_gnt;
                    addr_d  = slot_addr_q[pick_idx];
                    dout_d  = slot_dtw_q[pick_idx];
                    rw_d    = slot_rw_q[pick_idx];
                    kill_d  = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWait;
                if (flush) begin
                    kill_d = 1'b1;
                end
            end
            StWait: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (ack) begin
                    done = 1'b1;
                end else if (TIMEOUT != 0 && tmo_q == TmoLast) begin
                    done  = 1'b1;
                    timed = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (done) begin
                    state_d = StIdle;
                    kill_d  = 1'b0;
                    if (!kill_q && !flush) begin
                        ack_d[own_q] = 1'b1;
                        err_d[own_q] = timed;
                        dtr_d[own_q] = timed ? '0 : din;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        pend_d = flush ? '0 : (pend_d | cap);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
            own_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            rw_q    <= RwRead;
            tmo_q   <= '0;
            kill_q  <= 1'b0;
            dtr_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            own_q   <= own_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rw_q    <= rw_d;
            tmo_q   <= tmo_d;
            kill_q  <= kill_d;
            dtr_q   <= dtr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_addr_q <= '0;
            slot_dtw_q  <= '0;
            slot_rw_q   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cap[i]) begin
                    slot_addr_q[i] <= ch_addr[i*AW +: AW];
                    slot_dtw_q[i]  <= ch_dtw[i*DW +: DW];
                    slot_rw_q[i]   <= ch_rw[i];
                end
            end
        end
    end

endmodule
